// File: rtl/grid_coord_scanner.sv
// Raster-scan (row-major) coordinate generator with valid/ready output handshake.
// Define SCAN_CONTINUOUS_EN to wrap from the last cell straight back to (0,0) without leaving SCAN.
module grid_coord_scanner #(
  parameter int GRID_H      = 16,
  parameter int GRID_W      = 16,
  parameter int X_WIDTH     = $clog2(GRID_H*GRID_W),
  parameter int Y_WIDTH     = $clog2(GRID_W),
  parameter int ADDR_WIDTH  = $clog2(GRID_H*GRID_W),
  parameter int SWEEP_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [X_WIDTH-1:0]     x,
  output logic [Y_WIDTH-1:0]     y,
  output logic [ADDR_WIDTH-1:0]  addr,
  output logic                   first,
  output logic                   last,
  output logic                   busy,
  output logic                   done,
  output logic [SWEEP_WIDTH-1:0] sweep_count
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  localparam logic [X_WIDTH-1:0] X_MAX          = X_WIDTH'(GRID_H - 1);
  localparam logic [Y_WIDTH-1:0] Y_MAX          = Y_WIDTH'(GRID_W - 1);
  localparam logic               LAST_AT_ORIGIN = (GRID_H == 1) && (GRID_W == 1);

  state_t                 state_q, state_d;
  logic                   out_valid_q, out_valid_d;
  logic [X_WIDTH-1:0]     x_q, x_d, x_nxt;
  logic [Y_WIDTH-1:0]     y_q, y_d, y_nxt;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   first_q, first_d;
  logic                   last_q, last_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [SWEEP_WIDTH-1:0] sweep_q, sweep_d;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    x_d         = x_q;
    y_d         = y_q;
    addr_d      = addr_q;
    first_d     = first_q;
    last_d      = last_q;
    done_d      = 1'b0;
    sweep_d     = sweep_q;

    if (y_q == Y_MAX) begin
      y_nxt = '0;
      x_nxt = X_WIDTH'(x_q + 1'b1);
    end else begin
      y_nxt = Y_WIDTH'(y_q + 1'b1);
      x_nxt = x_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_SCAN;
          out_valid_d = 1'b1;
          x_d         = '0;
          y_d         = '0;
          addr_d      = '0;
          first_d     = 1'b1;
          last_d      = LAST_AT_ORIGIN;
        end
      end
      S_SCAN: begin
        if (abort) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          x_d         = '0;
          y_d         = '0;
          addr_d      = '0;
          first_d     = 1'b0;
          last_d      = 1'b0;
        end else if (out_valid_q && out_ready) begin
          if (last_q) begin
            done_d  = 1'b1;
            sweep_d = SWEEP_WIDTH'(sweep_q + 1'b1);
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
`ifdef SCAN_CONTINUOUS_EN
            first_d = 1'b1;
            last_d  = LAST_AT_ORIGIN;
`else
            state_d     = S_DONE;
            out_valid_d = 1'b0;
            first_d     = 1'b0;
            last_d      = 1'b0;
`endif
          end else begin
            x_d     = x_nxt;
            y_d     = y_nxt;
            addr_d  = ADDR_WIDTH'(addr_q + 1'b1);
            first_d = 1'b0;
            // flags follow the coordinate being loaded, not the one leaving
            last_d  = (x_nxt == X_MAX) && (y_nxt == Y_MAX);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sweep_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      first_q     <= first_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sweep_q     <= sweep_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign x           = x_q;
  assign y           = y_q;
  assign addr        = addr_q;
  assign first       = first_q;
  assign last        = last_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign sweep_count = sweep_q;

endmodule

// File: tb/tb_grid_coord_scanner.sv
// Self-checking bench for grid_coord_scanner: cell-index reference model plus directed scenarios.
// Build with SCAN_CONTINUOUS_EN defined to exercise the wrap-around mode.
module tb_grid_coord_scanner;
  localparam int H = 16;
  localparam int W = 16;
  localparam int N = H * W;
`ifdef SCAN_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, abort, out_ready;
  logic        out_valid, first, last, busy, done;
  logic [7:0]  x;
  logic [3:0]  y;
  logic [7:0]  addr;
  logic [15:0] sweep_count;

  grid_coord_scanner dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .out_ready(out_ready),
    .out_valid(out_valid), .x(x), .y(y), .addr(addr), .first(first), .last(last),
    .busy(busy), .done(done), .sweep_count(sweep_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference: the cell on offer is just an index into the raster order
  bit m_valid, m_busy, m_done;
  int m_idx, m_sweeps;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit a, input bit rdy);
    if (r) begin
      m_valid = 0; m_busy = 0; m_done = 0; m_idx = 0; m_sweeps = 0;
    end else if (m_valid) begin
      if (a) begin
        m_valid = 0; m_busy = 0; m_done = 0;
      end else if (rdy && m_idx == N - 1) begin
        m_sweeps = (m_sweeps + 1) % 65536;
        m_done   = 1;
        m_idx    = 0;
        if (!CONT) m_valid = 0;
      end else begin
        m_done = 0;
        if (rdy) m_idx++;
      end
    end else if (m_busy) begin
      m_busy = 0; m_done = 0;
    end else if (s) begin
      m_valid = 1; m_busy = 1; m_idx = 0; m_done = 0;
    end
  endtask

  task automatic compare();
    chk("out_valid", out_valid, m_valid);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("sweep_count", sweep_count, m_sweeps);
    if (m_valid) begin
      chk("x", x, m_idx / W);
      chk("y", y, m_idx % W);
      chk("addr", addr, m_idx);
      chk("first", first, m_idx == 0);
      chk("last", last, m_idx == N - 1);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit a, input bit rdy);
    reset = r; start = s; abort = a; out_ready = rdy;
    @(posedge clk);
    model_step(r, s, a, rdy);
    @(negedge clk);
    compare();
  endtask

  initial begin
    int n;
    int saved;
    bit found;
    reset = 1; start = 0; abort = 0; out_ready = 0;
    m_valid = 0; m_busy = 0; m_done = 0; m_idx = 0; m_sweeps = 0;
    @(negedge clk);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sweep", sweep_count, 0);
    chk("rst_addr", addr, 0);

    // full sweep, out_ready held high; edge 1 samples start
    step(0, 1, 0, 1);
    chk("t1_first_valid", out_valid, 1);
    chk("t1_first_flag", first, 1);
    chk("t1_first_addr", addr, 0);
    n = 1; found = 0;
    while (n < 400 && !found) begin
      step(0, 0, 0, 1);
      n++;
      if (done) found = 1;
    end
    chk("t1_done_edge", n, 257);
    chk("t1_sweep", sweep_count, 1);
`ifdef SCAN_CONTINUOUS_EN
    chk("t1_wrap_valid", out_valid, 1);
    chk("t1_wrap_first", first, 1);
    step(0, 0, 1, 1);
    chk("t1_abort_valid", out_valid, 0);
`else
    chk("t1_done_valid", out_valid, 0);
    step(0, 1, 0, 1);
    chk("t1_idle_busy", busy, 0);
    chk("t1_start_ignored", out_valid, 0);
`endif
    step(0, 0, 0, 1);

    // start pulsed mid-sweep at addr 100 must do nothing
    step(0, 1, 0, 1);
    n = 0; found = 0;
    while (n < 400 && !found) begin
      step(0, m_valid && m_idx == 100, 0, 1);
      n++;
      if (done) found = 1;
    end
    chk("t3_sweep", sweep_count, 2);
    step(0, 0, CONT, 1);
    step(0, 0, 0, 1);

    // abort at addr 37 with an accept in the same cycle
    saved = m_sweeps;
    step(0, 1, 0, 1);
    n = 0;
    while (n < 100 && m_idx != 37) begin
      step(0, 0, 0, 1);
      n++;
    end
    chk("t4_reach", addr, 37);
    step(0, 0, 1, 1);
    chk("t4_valid", out_valid, 0);
    chk("t4_done", done, 0);
    chk("t4_sweep", sweep_count, saved);
    step(0, 0, 0, 1);
    chk("t4_no_late_done", done, 0);

    // reset at addr 200, then restart
    step(0, 1, 0, 1);
    n = 0;
    while (n < 300 && m_idx != 200) begin
      step(0, 0, 0, 1);
      n++;
    end
    chk("t5_reach", addr, 200);
    step(1, 0, 0, 1);
    chk("t5_valid", out_valid, 0);
    chk("t5_x", x, 0);
    chk("t5_addr", addr, 0);
    chk("t5_sweep", sweep_count, 0);
    step(0, 1, 0, 1);
    chk("t5_restart_first", first, 1);
    chk("t5_restart_y", y, 0);

`ifdef SCAN_CONTINUOUS_EN
    // 768 consecutive accepts from the fresh sweep above -> three wraps
    for (int i = 0; i < 768; i++) step(0, 0, 0, 1);
    chk("t6_sweep", sweep_count, 3);
    chk("t6_done", done, 1);
    chk("t6_first", first, 1);
    chk("t6_valid", out_valid, 1);
`endif
    step(0, 0, 1, 1);

    // randomized traffic: 50% ready, occasional start/abort/reset
    for (int i = 0; i < 6000; i++) begin
      step($urandom_range(0, 999) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 1499) == 0, $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
